// File: rtl/crossover_controller.sv
// crossover_controller: gene-wise uniform crossover sequencer.
// Builds one child genome from two latched parent genomes, one gene per clock.
// For each gene it decides select = (prob > random) ^ bias, where random comes
// from an internal 16-bit Fibonacci LFSR. A start/busy/done handshake frames
// each run.
// Optional build macro: XOVER_SINGLE_POINT_EN adds a single_point input. In that
// mode the first gene that selects parent B, and every gene after it, takes
// parent B.

// Per-gene update lane: rewrites its gene only while it is the active index.
module xover_gene_lane #(
  parameter int GENE_W = 4
) (
  input  logic              en,
  input  logic              sel,
  input  logic [GENE_W-1:0] gene_a,
  input  logic [GENE_W-1:0] gene_b,
  input  logic [GENE_W-1:0] gene_cur,
  output logic [GENE_W-1:0] gene_nxt
);
  // Hold the old value unless this lane is selected this cycle.
  always_comb begin
    gene_nxt = gene_cur;
    if (en) gene_nxt = sel ? gene_b : gene_a;
  end
endmodule

module crossover_controller #(
  parameter int          NUM_GENES = 8,
  parameter int          GENE_W    = 4,
  parameter int          PROB_W    = 4,
  parameter logic [15:0] LFSR_INIT = 16'hACE1,
  localparam int         IDX_W     = (NUM_GENES > 2) ? $clog2(NUM_GENES) : 1,
  localparam int         CW        = NUM_GENES * GENE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     parent_a,
  input  logic [CW-1:0]     parent_b,
  input  logic [PROB_W-1:0] prob,
  input  logic              bias,
  input  logic              seed_load,
  input  logic [15:0]       seed,
`ifdef XOVER_SINGLE_POINT_EN
  input  logic              single_point,
`endif
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  gene_idx,
  output logic [CW-1:0]     child
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_GENES - 1);

  state_t                              state_q, state_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic [IDX_W-1:0]                    gene_idx_q, gene_idx_d;
  logic [NUM_GENES-1:0][GENE_W-1:0]    child_q, child_d, child_nxt;
  logic [NUM_GENES-1:0][GENE_W-1:0]    a_l_q, a_l_d;
  logic [NUM_GENES-1:0][GENE_W-1:0]    b_l_q, b_l_d;
  logic [PROB_W-1:0]                   prob_l_q, prob_l_d;
  logic                                bias_l_q, bias_l_d;
  logic [15:0]                         lfsr_q, lfsr_d;
  logic                                sp_l_q, sp_l_d;
  logic                                sticky_q, sticky_d;

  logic              run;
  logic [PROB_W-1:0] rnd;
  logic              sel_raw;
  logic              sel;
  logic              lfsr_fb;
  logic              sp_in;

`ifdef XOVER_SINGLE_POINT_EN
  assign sp_in = single_point;
`else
  assign sp_in = 1'b0;
`endif

  assign run     = (state_q == RUN);
  // The compare uses the LFSR value from before this cycle's step.
  assign rnd     = lfsr_q[PROB_W-1:0];
  assign sel_raw = (prob_l_q > rnd) ^ bias_l_q;
  // After the single-point crossing, later genes stay on parent B.
  assign sel     = sel_raw | (sp_l_q & sticky_q);
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // One lane per gene. Only the lane matching gene_idx updates, and only in RUN.
  for (genvar g = 0; g < NUM_GENES; g++) begin : g_lane
    xover_gene_lane #(.GENE_W(GENE_W)) u_lane (
      .en       (run && (gene_idx_q == IDX_W'(g))),
      .sel      (sel),
      .gene_a   (a_l_q[g]),
      .gene_b   (b_l_q[g]),
      .gene_cur (child_q[g]),
      .gene_nxt (child_nxt[g])
    );
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    gene_idx_d = gene_idx_q;
    child_d    = child_nxt;
    a_l_d      = a_l_q;
    b_l_d      = b_l_q;
    prob_l_d   = prob_l_q;
    bias_l_d   = bias_l_q;
    lfsr_d     = lfsr_q;
    sp_l_d     = sp_l_q;
    sticky_d   = sticky_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          // Start has priority over seed_load. A seed that arrives with start is dropped.
          a_l_d      = parent_a;
          b_l_d      = parent_b;
          prob_l_d   = prob;
          bias_l_d   = bias;
          sp_l_d     = sp_in;
          sticky_d   = 1'b0;
          gene_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = RUN;
        end else if (seed_load) begin
          // An all-zero seed would lock the LFSR, so it is replaced by the init value.
          lfsr_d = (seed == 16'h0000) ? LFSR_INIT : seed;
        end
      end
      RUN: begin
        lfsr_d = {lfsr_q[14:0], lfsr_fb};
        if (sp_l_q && sel) sticky_d = 1'b1;
        if (gene_idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          gene_idx_d = gene_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. An async reset aborts any run, with no done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gene_idx_q <= '0;
      child_q    <= '0;
      a_l_q      <= '0;
      b_l_q      <= '0;
      prob_l_q   <= '0;
      bias_l_q   <= 1'b0;
      lfsr_q     <= LFSR_INIT;
      sp_l_q     <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gene_idx_q <= gene_idx_d;
      child_q    <= child_d;
      a_l_q      <= a_l_d;
      b_l_q      <= b_l_d;
      prob_l_q   <= prob_l_d;
      bias_l_q   <= bias_l_d;
      lfsr_q     <= lfsr_d;
      sp_l_q     <= sp_l_d;
      sticky_q   <= sticky_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign gene_idx = gene_idx_q;
  assign child    = child_q;

endmodule

// File: tb/tb_crossover_controller.sv
// Testbench for crossover_controller. Directed and randomized runs are checked
// against a behavioural model. The model represents the LFSR as an integer and
// applies the select rule one gene at a time.
module tb_crossover_controller;
  localparam int NG = 8;
  localparam int GW = 4;
  localparam int PW = 4;
  localparam int CW = NG * GW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] pa, pb;
  logic [PW-1:0] prob;
  logic          bias;
  logic          seed_load;
  logic [15:0]   seed;
  logic          single_point;
  logic          busy, done;
  logic [2:0]    gene_idx;
  logic [CW-1:0] child;

  crossover_controller #(
    .NUM_GENES(NG), .GENE_W(GW), .PROB_W(PW), .LFSR_INIT(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .parent_a(pa), .parent_b(pb),
    .prob(prob), .bias(bias),
    .seed_load(seed_load), .seed(seed),
`ifdef XOVER_SINGLE_POINT_EN
    .single_point(single_point),
`endif
    .busy(busy), .done(done), .gene_idx(gene_idx), .child(child)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            lfsr_m = 'hACE1;
  logic [CW-1:0] child_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_next(input int l);
    int fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
    return ((l << 1) | fb) & 'hFFFF;
  endfunction

  // Reference model: advances lfsr_m and rewrites child_m for one full run.
  task automatic model_run(input logic [CW-1:0] a, input logic [CW-1:0] b,
                           input int p, input bit bi, input bit sp);
    bit sticky = 0;
    bit sel;
    int r;
    for (int g = 0; g < NG; g++) begin
      r   = lfsr_m % (1 << PW);
      sel = (p > r) ^ bi;
      if (sp) begin
        if (sticky) sel = 1;
        if (sel) sticky = 1;
      end
      child_m[g*GW +: GW] = sel ? b[g*GW +: GW] : a[g*GW +: GW];
      lfsr_m = lfsr_next(lfsr_m);
    end
  endtask

  // First gene index that selects parent B for a given starting LFSR value.
  function automatic int first_sel(input int s, input int p, input bit bi);
    int l = s;
    for (int g = 0; g < NG; g++) begin
      if (((p > (l % (1 << PW))) ^ bi) != 0) return g;
      l = lfsr_next(l);
    end
    return NG;
  endfunction

  task automatic load_seed(input logic [15:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    @(posedge clk);
    @(negedge clk);
    seed_load = 1'b0;
    lfsr_m = (s == 16'h0) ? 'hACE1 : int'(s);
  endtask

  // One full run. If disturb is set, the inputs are changed and start/seed_load are
  // pulsed mid-run. If sl is set, seed_load is raised together with start.
  task automatic do_run(input string tag, input logic [CW-1:0] a, input logic [CW-1:0] b,
                        input int p, input bit bi, input bit sp, input bit disturb, input bit sl);
    logic [CW-1:0] held;
    @(negedge clk);
    pa = a; pb = b; prob = PW'(p); bias = bi; single_point = sp;
    start = 1'b1;
    seed_load = sl; seed = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; seed_load = 1'b0;
    model_run(a, b, p, bi, sp);
    if (disturb) begin
      pa = $urandom; pb = $urandom; prob = PW'($urandom); bias = ~bi;
    end
    for (int k = 0; k < NG; k++) begin
      check({tag, ".busy"}, 64'(busy), 64'd1);
      check({tag, ".idx"}, 64'(gene_idx), 64'(k));
      check({tag, ".nodone"}, 64'(done), 64'd0);
      if (disturb && k == 2) begin
        start = 1'b1; seed_load = 1'b1; seed = 16'(($urandom % 'hFFFF) + 1);
      end
      if (disturb && k == 5) begin
        start = 1'b0; seed_load = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".busy_off"}, 64'(busy), 64'd0);
    check({tag, ".child"}, 64'(child), 64'(child_m));
    held = child;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".idle_busy"}, 64'(busy), 64'd0);
    check({tag, ".held"}, 64'(child), 64'(held));
  endtask

  initial begin
    int s;
    rst = 1'b0; start = 1'b0; pa = '0; pb = '0; prob = '0; bias = 1'b0;
    seed_load = 1'b0; seed = '0; single_point = 1'b0;
    #12;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.idx", 64'(gene_idx), 64'd0);
    check("rst.child", 64'(child), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // prob=0 makes sel equal to bias for every gene.
    do_run("p0b0", 32'h01234567, 32'h89ABCDEF, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("p0b0.const", 64'(child), 64'h01234567);
    do_run("p0b1", 32'h01234567, 32'h89ABCDEF, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("p0b1.const", 64'(child), 64'h89ABCDEF);

    // Seeded run, then a second run without reloading, which continues the sequence.
    load_seed(16'h0001);
    do_run("seed1a", 32'h01234567, 32'h89ABCDEF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    do_run("seed1b", 32'hFEDCBA98, 32'h76543210, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    load_seed(16'h0000);
    do_run("seed0", 32'h01234567, 32'h89ABCDEF, 8, 1'b0, 1'b0, 1'b0, 1'b0);

    // Max probability: sel is ~bias unless random is all-ones.
    do_run("pmax", 32'h11111111, 32'hEEEEEEEE, 15, 1'b0, 1'b0, 1'b0, 1'b0);

    // Mid-run start/seed_load/input changes are ignored. A seed that arrives with start is dropped.
    do_run("disturb", 32'hA5A5A5A5, 32'h5A5A5A5A, 7, 1'b0, 1'b0, 1'b1, 1'b0);
    do_run("start_seed", 32'h0F0F0F0F, 32'hF0F0F0F0, 9, 1'b1, 1'b0, 1'b0, 1'b1);

    // Randomized runs, some with a fresh seed.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) load_seed(16'($urandom));
      do_run("rand", 32'($urandom), 32'($urandom), int'($urandom_range(0, 15)),
             1'($urandom), 1'b0, 1'b0, 1'b0);
    end

    // Async reset at gene 3: all outputs return to reset values and no done pulse follows.
    @(negedge clk);
    pa = 32'h13579BDF; pb = 32'h2468ACE0; prob = 4'd8; bias = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && gene_idx != 3'd3; c++) @(negedge clk);
    check("rstmid.reach3", 64'(gene_idx), 64'd3);
    rst = 1'b0;
    #1;
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.done", 64'(done), 64'd0);
    check("rstmid.idx", 64'(gene_idx), 64'd0);
    check("rstmid.child", 64'(child), 64'd0);
    lfsr_m  = 'hACE1;
    child_m = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rstmid.nodone", 64'(done), 64'd0);
    end
    rst = 1'b1;
    do_run("after_rst", 32'h13579BDF, 32'h2468ACE0, 8, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef XOVER_SINGLE_POINT_EN
    // Pick a seed whose first parent-B select lands on gene 2.
    s = 1;
    while (s < 'h10000 && first_sel(s, 8, 1'b0) != 2) s++;
    check("sp.seed_found", 64'(first_sel(s, 8, 1'b0)), 64'd2);
    load_seed(16'(s));
    do_run("sp", 32'h01234567, 32'h89ABCDEF, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    check("sp.split", 64'(child), 64'h89ABCD67);
    do_run("sp_off", 32'h01234567, 32'h89ABCDEF, 8, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    s = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
